// File: rtl/game_over_ctrl.sv
// game_over_ctrl: end-of-game banner sequencer.
// Tracks lives and the alien-landed / aliens-cleared events, freezes play
// when the game ends, scrolls the loser/winner banner on a divided tick,
// holds it, then waits for a restart press and pulses game_reset.
// Optional feature macro: GAME_OVER_WINNER_EN (enables the win sequence).
// Handshake note: all event inputs are single-cycle pulses with no ready
// back-pressure; an event is consumed on the edge it is sampled, or dropped
// if the current state ignores it.
// state_dbg encoding: 0=PLAY 1=SCROLL 2=HOLD 3=WAIT.
module game_over_ctrl #(
  parameter int LIVES      = 3,
  parameter int TICK_DIV   = 1000000,
  parameter int START_ROW  = 480,
  parameter int STOP_ROW   = 120,
  parameter int STEP       = 3,
  parameter int HOLD_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        player_hit,
  input  logic        alien_landed,
  input  logic        aliens_cleared,
  input  logic        restart,
  output logic        loser,
  output logic        winner,
  output logic        freeze,
  output logic [11:0] banner_row,
  output logic [2:0]  lives,
  output logic        game_reset,
  output logic [1:0]  state_dbg
);

`ifdef GAME_OVER_WINNER_EN
  localparam logic WIN_EN = 1'b1;
`else
  localparam logic WIN_EN = 1'b0;
`endif

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [11:0]   ROW_START = 12'(START_ROW);
  localparam logic [11:0]   ROW_STOP  = 12'(STOP_ROW);
  localparam logic [11:0]   ROW_STEP  = 12'(STEP);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  typedef enum logic [1:0] {S_PLAY = 2'd0, S_SCROLL = 2'd1, S_HOLD = 2'd2, S_WAIT = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic [HW-1:0] hold_cnt_q;

  logic        tick;
  logic        ev_lose, ev_last_hit, ev_dec, ev_win;
  logic [11:0] row_next;
  logic        scroll_done, hold_done;

  logic        loser_d, winner_d, freeze_d, game_reset_d;
  logic [11:0] banner_row_d;
  logic [2:0]  lives_d;

  assign state_dbg = state_q;

  // Event decode and scroll arithmetic shared by next-state and output logic
  always_comb begin
    tick        = ((state_q == S_SCROLL) || (state_q == S_HOLD)) && (tick_cnt_q == TICK_LAST);
    ev_last_hit = player_hit && !alien_landed && (lives == 3'd1);
    ev_lose     = alien_landed || ev_last_hit;
    ev_dec      = player_hit && !alien_landed && (lives > 3'd1);
    ev_win      = WIN_EN && aliens_cleared && !ev_lose;
    // Saturating subtract so the banner never passes its stop row
    row_next    = (banner_row >= (ROW_STOP + ROW_STEP)) ? (banner_row - ROW_STEP) : ROW_STOP;
    scroll_done = tick && (row_next == ROW_STOP);
    hold_done   = tick && (hold_cnt_q == HOLD_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_PLAY;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLAY:   if (ev_lose || ev_win) state_d = S_SCROLL;
      S_SCROLL: if (scroll_done)       state_d = S_HOLD;
      S_HOLD:   if (hold_done)         state_d = S_WAIT;
      S_WAIT:   if (restart)           state_d = S_PLAY;
      default:                         state_d = S_PLAY;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    loser_d      = loser;
    winner_d     = winner;
    freeze_d     = freeze;
    banner_row_d = banner_row;
    lives_d      = lives;
    game_reset_d = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (ev_lose) begin
          loser_d  = 1'b1;
          freeze_d = 1'b1;
          if (ev_last_hit) lives_d = 3'd0;
        end else begin
          if (ev_dec) lives_d = lives - 3'd1;
          if (ev_win) begin
            winner_d = 1'b1;
            freeze_d = 1'b1;
          end
        end
      end
      S_SCROLL: if (tick) banner_row_d = row_next;
      S_WAIT: begin
        if (restart) begin
          game_reset_d = 1'b1;
          lives_d      = LIVES_INIT;
          banner_row_d = ROW_START;
          loser_d      = 1'b0;
          winner_d     = 1'b0;
          freeze_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers; counters idle at zero outside SCROLL/HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loser      <= 1'b0;
      winner     <= 1'b0;
      freeze     <= 1'b0;
      game_reset <= 1'b0;
      banner_row <= ROW_START;
      lives      <= LIVES_INIT;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      loser      <= loser_d;
      winner     <= winner_d;
      freeze     <= freeze_d;
      game_reset <= game_reset_d;
      banner_row <= banner_row_d;
      lives      <= lives_d;
      if ((state_q == S_SCROLL) || (state_q == S_HOLD))
        tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      else
        tick_cnt_q <= '0;
      if (state_q != S_HOLD)
        hold_cnt_q <= '0;
      else if (tick)
        hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

endmodule
